// File: rtl/shift_left_deserializer.sv
// Serial-in, parallel-out converter with a one-word output buffer.
// Bits arrive on a valid/ready serial port, are shifted into a WIDTH-bit
// register and each completed word is presented on a valid/ready parallel
// port. Collection of the next word overlaps with draining of the previous one.
//
// Optional feature (macro PARITY_CHECK_EN): each frame carries one trailing
// even-parity bit that is checked but not stored; out_parity_err is then
// registered alongside out_data.
module shift_left_deserializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ser_in,
  input  logic             ser_valid,
  output logic             ser_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
`ifdef PARITY_CHECK_EN
  ,
  output logic             out_parity_err
`endif
);

`ifdef PARITY_CHECK_EN
  localparam int FRAME_BITS = WIDTH + 1;
`else
  localparam int FRAME_BITS = WIDTH;
`endif
  localparam int            CNT_W = $clog2(FRAME_BITS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_BITS - 1);

  typedef enum logic {
    COLLECT = 1'b0,  // accepting serial bits
    FULL    = 1'b1   // completed word parked in sh, waiting for the buffer
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] sh, sh_next;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             data_bit;
  logic             word_done;
  logic             buf_free;

  assign accept    = ser_valid && ser_ready;
  assign word_done = accept && (cnt == LAST);
  assign buf_free  = !out_valid || out_ready;

`ifdef PARITY_CHECK_EN
  // The final bit of a frame is the parity bit and never enters sh.
  assign data_bit = (cnt != LAST);
`else
  assign data_bit = 1'b1;
`endif

  // Shift-register next value; the assembled word on the completing edge.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    sh_next = sh;
    if (accept && data_bit) begin
      if (MSB_FIRST) sh_next = {sh[WIDTH-2:0], ser_in};
      else           sh_next = {ser_in, sh[WIDTH-1:1]};
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) state <= COLLECT;
    else        state <= state_next;
  end

  // Next-state and serial-side ready.
  always_comb begin
    state_next = state;
    ser_ready  = 1'b0;
    case (state)
      COLLECT: begin
        ser_ready = rst_n;
        if (word_done && !buf_free) state_next = FULL;
      end
      FULL: begin
        if (out_valid && out_ready) state_next = COLLECT;
      end
      default: state_next = COLLECT;
    endcase
  end

  // Shift register, bit counter and output buffer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh        <= '0;
      cnt       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      if (accept) begin
        sh  <= sh_next;
        cnt <= word_done ? '0 : cnt + 1'b1;
      end
      if (word_done && buf_free) begin
        out_data  <= sh_next;
        out_valid <= 1'b1;
      end else if (state == FULL && out_ready) begin
        out_data  <= sh;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef PARITY_CHECK_EN
  logic par_acc;

  // Running XOR over the frame; it follows a parked word into FULL.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      par_acc        <= 1'b0;
      out_parity_err <= 1'b0;
    end else begin
      if (word_done && buf_free) begin
        par_acc        <= 1'b0;
        out_parity_err <= par_acc ^ ser_in;
      end else if (accept) begin
        par_acc <= par_acc ^ ser_in;
      end else if (state == FULL && out_ready) begin
        par_acc        <= 1'b0;
        out_parity_err <= par_acc;
      end
    end
  end
`endif

endmodule

// File: tb/tb_shift_left_deserializer.sv
// Directed bench for shift_left_deserializer. Two instances share the serial
// stream: one MSB-first, one LSB-first. When PARITY_CHECK_EN is defined every
// frame is followed by its even-parity bit and the parity cases are exercised.
module tb_shift_left_deserializer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ser_in;
  logic       ser_valid;
  logic       out_ready;
  logic       ser_ready_m, ser_ready_l;
  logic [7:0] out_data_m, out_data_l;
  logic       out_valid_m, out_valid_l;
`ifdef PARITY_CHECK_EN
  logic       perr_m, perr_l;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  shift_left_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk       (clk),
    .rst_n     (rst_n),
    .ser_in    (ser_in),
    .ser_valid (ser_valid),
    .ser_ready (ser_ready_m),
    .out_data  (out_data_m),
    .out_valid (out_valid_m),
    .out_ready (out_ready)
`ifdef PARITY_CHECK_EN
    ,
    .out_parity_err (perr_m)
`endif
  );

  shift_left_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk       (clk),
    .rst_n     (rst_n),
    .ser_in    (ser_in),
    .ser_valid (ser_valid),
    .ser_ready (ser_ready_l),
    .out_data  (out_data_l),
    .out_valid (out_valid_l),
    .out_ready (out_ready)
`ifdef PARITY_CHECK_EN
    ,
    .out_parity_err (perr_l)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of serial input at the falling edge.
  task automatic drive(input logic v, input logic b);
    @(negedge clk);
    ser_valid = v;
    ser_in    = b;
  endtask

  // Send bits lo..7 of w MSB-first, then the parity bit if frames carry one.
  task automatic send_range(input logic [7:0] w, input int lo);
    for (int i = lo; i < 8; i++) drive(1'b1, w[7-i]);
`ifdef PARITY_CHECK_EN
    drive(1'b1, ^w);
`endif
  endtask

  initial begin
    rst_n = 1'b0; ser_valid = 1'b0; ser_in = 1'b0; out_ready = 1'b1;

    // Reset state.
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    check("rst_out_valid", out_valid_m, 0);
    check("rst_out_data", out_data_m, 0);
    check("rst_ser_ready", ser_ready_m, 0);
    rst_n = 1'b1;
    drive(1'b0, 1'b0);
    check("post_rst_ser_ready", ser_ready_m, 1);

    // Bits 0,...,0,1: 01 MSB-first, 80 LSB-first, valid for one cycle.
    send_range(8'h01, 0);
    drive(1'b0, 1'b0);
    check("msb_word", out_data_m, 8'h01);
    check("msb_valid", out_valid_m, 1);
    check("lsb_word", out_data_l, 8'h80);
    check("lsb_valid", out_valid_l, 1);
    drive(1'b0, 1'b0);
    check("msb_valid_drop", out_valid_m, 0);

    // Backpressure: 3C then C3 with out_ready low.
    out_ready = 1'b0;
    send_range(8'h3C, 0);
    send_range(8'hC3, 0);
    drive(1'b0, 1'b0);
    check("bp_first_word", out_data_m, 8'h3C);
    check("bp_valid", out_valid_m, 1);
    check("bp_full_ready", ser_ready_m, 0);
    drive(1'b0, 1'b0);
    check("bp_hold_word", out_data_m, 8'h3C);
    check("bp_hold_ready", ser_ready_m, 0);
    out_ready = 1'b1;
    drive(1'b0, 1'b0);
    out_ready = 1'b0;
    check("bp_second_word", out_data_m, 8'hC3);
    check("bp_second_valid", out_valid_m, 1);
    check("bp_ready_back", ser_ready_m, 1);
    drive(1'b0, 1'b0);
    check("bp_second_hold", out_data_m, 8'hC3);
    out_ready = 1'b1;
    drive(1'b0, 1'b0);
    check("bp_drained", out_valid_m, 0);

    // Idle cycles interleaved with the bits of A6 do not advance the counter.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, ((8'hA6 >> (7 - i)) & 8'h01) != 0);
      drive(1'b0, 1'b0);
      if (i == 6) check("gap_no_early_word", out_valid_m, 0);
    end
`ifdef PARITY_CHECK_EN
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
`endif
    check("gap_word_msb", out_data_m, 8'hA6);
    check("gap_valid", out_valid_m, 1);
    check("gap_word_lsb", out_data_l, 8'h65);
    drive(1'b0, 1'b0);

    // Back-to-back words at full rate: no bubble, never FULL.
    send_range(8'h5A, 0);
    drive(1'b1, 1'b1);
    check("b2b_first", out_data_m, 8'h5A);
    check("b2b_first_valid", out_valid_m, 1);
    check("b2b_ready", ser_ready_m, 1);
    send_range(8'h96, 1);
    drive(1'b0, 1'b0);
    check("b2b_second", out_data_m, 8'h96);
    check("b2b_second_valid", out_valid_m, 1);
    drive(1'b0, 1'b0);

    // Reset mid-word discards the three partial bits.
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b1);
    @(negedge clk);
    ser_valid = 1'b0;
    rst_n = 1'b0;
    drive(1'b0, 1'b0);
    check("mid_rst_valid", out_valid_m, 0);
    check("mid_rst_ready", ser_ready_m, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1);
    drive(1'b0, 1'b0);
    check("mid_rst_no_leftover", out_valid_m, 0);
    send_range(8'hFF, 5);
    drive(1'b0, 1'b0);
    check("mid_rst_word", out_data_m, 8'hFF);
    check("mid_rst_word_valid", out_valid_m, 1);
    check("mid_rst_word_lsb", out_data_l, 8'hFF);
    drive(1'b0, 1'b0);

`ifdef PARITY_CHECK_EN
    // 07 has three ones: parity bit 1 is good, 0 is bad.
    for (int i = 0; i < 8; i++) drive(1'b1, i >= 5);
    drive(1'b1, 1'b1);
    drive(1'b0, 1'b0);
    check("par_good_data", out_data_m, 8'h07);
    check("par_good_err", perr_m, 0);
    for (int i = 0; i < 8; i++) drive(1'b1, i >= 5);
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    check("par_bad_data", out_data_m, 8'h07);
    check("par_bad_valid", out_valid_m, 1);
    check("par_bad_err", perr_m, 1);
    drive(1'b0, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule

// File: doc/shift_left_deserializer.md
Name: shift_left_deserializer

Overview:
- Serial-in, parallel-out converter. It is the receive-side counterpart of the parallel-to-serial shift logic in the simple logic-elements library.
- Accepts one bit per cycle on a valid/ready serial input. Shifts bits into a WIDTH-bit register and presents each completed word on a valid/ready parallel output.
- Holds a one-word output buffer, so collection of the next word overlaps with draining of the previous one.

Parameters:
- WIDTH, default 8: parallel word width in bits, must be >= 2.
- MSB_FIRST, default 1:
  - 1: first received bit lands in bit WIDTH-1 (shift left).
  - 0: first received bit lands in bit 0 (shift right).

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- ser_in  in  1  serial data bit.
- ser_valid  in  1  ser_in is valid this cycle.
- ser_ready  out  1  block accepts a bit this cycle.
- out_data  out  WIDTH  assembled word.
- out_valid  out  1  out_data holds a word.
- out_ready  in  1  consumer takes out_data this cycle.
- out_parity_err  out  1  present only with PARITY_CHECK_EN.

Behaviour:
- Reset is synchronous and active-low. At a clk edge with rst_n=0:
  - shift register and bit counter cleared to 0;
  - state set to COLLECT;
  - out_data set to 0, out_valid set to 0, out_parity_err set to 0.
- ser_ready is forced 0 while rst_n=0.
- Bit accept: ser_valid && ser_ready at a rising edge. Only then do the shift register and counter update; a cycle with ser_valid=0 changes nothing.
- Shift rule:
  - MSB_FIRST=1: sh <= {sh[WIDTH-2:0], ser_in}.
  - MSB_FIRST=0: sh <= {ser_in, sh[WIDTH-1:1]}.
- Bit counter runs 0..WIDTH-1 (0..WIDTH with parity) and wraps to 0 when a word completes.
- States:
  - COLLECT: ser_ready=1.
  - FULL: a complete word waits in the shift register; ser_ready=0.
- Word completion is the edge that accepts the last bit. On that edge:
  - If output buffer is free (!out_valid || out_ready): out_data <= assembled word, out_valid <= 1, stay in COLLECT. The word is visible in the cycle after the last bit is accepted (latency 1).
  - Otherwise: go to FULL and keep the word in sh.
- In FULL, when out_valid && out_ready: out_data <= sh, out_valid stays 1, state returns to COLLECT, counter is 0.
- Output handshake:
  - out_valid=1 && out_ready=1 with no new word completing: out_valid <= 0.
  - out_data and out_valid are stable while out_valid && !out_ready.
- Simultaneous drain and completion loads the new word with no bubble.
- Back-to-back words at full rate with out_ready=1 give one word every WIDTH cycles and never assert FULL.
- Reset mid-word discards the partial bits and any buffered or held word; the next accepted bit is bit 0 of a new word.
- No overrun is possible: the source must respect ser_ready.

Optional Feature:
- Macro: PARITY_CHECK_EN.
- Defined:
  - Each frame is WIDTH data bits followed by one even-parity bit; the parity bit is not shifted into the data.
  - Word completion happens on acceptance of the parity bit.
  - out_parity_err is registered with out_data: 1 when XOR(data bits, parity bit) = 1.
  - The word is still delivered when parity is bad.
- Undefined: the out_parity_err port does not exist and frames are WIDTH bits.

Test Plan:
- WIDTH=8, MSB_FIRST=1, out_ready=1, bits 0,0,0,0,0,0,0,1 on consecutive cycles -> out_data=8'h01, out_valid=1 for one cycle starting the cycle after the 8th bit.
- Same stimulus with MSB_FIRST=0 -> out_data=8'h80.
- out_ready=0, send 8'h3C then 8'hC3 back-to-back:
  - after the 16th bit, ser_ready=0, out_data=8'h3C held stable;
  - raise out_ready for one cycle -> out_data=8'hC3 next cycle, ser_ready=1.
- ser_valid toggling 1,0,1,0 during bits of 8'hA6 -> out_data=8'hA6; counter does not advance on idle cycles.
- Send 3 bits, pull rst_n=0 for one cycle, then send 8'hFF -> out_valid low during and after reset; the next word is 8'hFF with no leftover bits.
- PARITY_CHECK_EN defined:
  - 8'h07 plus parity bit 1 -> out_parity_err=0.
  - 8'h07 plus parity bit 0 -> out_parity_err=1, out_data=8'h07.
